// File: rtl/ram_block_mover_if.sv
// rtl/ram_block_mover_if.sv - command and RAM port bundle for the block mover
interface ram_block_mover_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  // command side
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill;
  logic          busy;
  logic          done;
  // RAM read port
  logic          re;
  logic [AW-1:0] ra;
  logic [DW-1:0] q;
  // RAM write port
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  // master: the mover engine
  modport master (
    input  start, mode, src, dst, len, fill, q,
    output busy, done, re, ra, we, wa, wd
  );

  // slave: CPU control unit plus RAM
  modport slave (
    output start, mode, src, dst, len, fill, q,
    input  busy, done, re, ra, we, wa, wd
  );
endinterface

// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - RAM block copy (memmove) and fill engine
module ram_block_mover #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               rst_n,
  ram_block_mover_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRIME   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FILLING = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [AW:0]   MAX_LEN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]    state;
  logic          busy;
  logic          done;
  logic [AW:0]   len_q;     // saturated word count of the accepted command
  logic          desc_q;    // copy walks addresses downward
  logic [AW-1:0] dst_base;  // destination of element issued first
  logic [AW:0]   cnt;       // reads issued (copy) or writes issued (fill)

  logic          re;
  logic [AW-1:0] ra;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;        // doubles as the single-word data register

  logic [AW:0]   len_sat;
  logic          desc_cmd;
  logic [AW-1:0] span;
  logic [AW-1:0] src_start;
  logic [AW-1:0] dst_start;
  logic [AW-1:0] ra_next;
  logic [AW-1:0] wa_next;
  logic          last_elem;
  logic          accept;

  // Decode the incoming command and the per-cycle address steps
  always_comb begin
    len_sat   = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
    // fills always run upward; copies run downward only when dst lies above src
    desc_cmd  = !bus.mode && (bus.dst > bus.src);
    // LEN-1 in address width; a full 2^AW block wraps to all ones as intended
    span      = len_sat[AW-1:0] - ADDR_ONE;
    src_start = desc_cmd ? bus.src + span : bus.src;
    dst_start = desc_cmd ? bus.dst + span : bus.dst;
    ra_next   = desc_q ? ra - ADDR_ONE : ra + ADDR_ONE;
    wa_next   = desc_q ? wa - ADDR_ONE : wa + ADDR_ONE;
    last_elem = (cnt == len_q);
    accept    = (state == S_IDLE) && bus.start;
  end

  // Sequencer: command latch, element counter, busy/done handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      desc_q   <= 1'b0;
      dst_base <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            len_q    <= len_sat;
            desc_q   <= desc_cmd;
            dst_base <= dst_start;
            cnt      <= CNT_ONE;
            if (len_sat == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= bus.mode ? S_FILLING : S_PRIME;
            end
          end
        end
        S_PRIME, S_STREAM: begin
          if (last_elem) begin
            state <= S_DRAIN;
          end else begin
            state <= S_STREAM;
            cnt   <= cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          state <= S_FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_FILLING: begin
          if (last_elem) begin
            state <= S_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read port: one read per cycle, running one element ahead of the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re <= 1'b0;
      ra <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (len_sat != '0) && !bus.mode) begin
            re <= 1'b1;
            ra <= src_start;
          end
        end
        S_PRIME, S_STREAM: begin
          if (last_elem) begin
            re <= 1'b0;
          end else begin
            ra <= ra_next;
          end
        end
        default: begin
          re <= 1'b0;
        end
      endcase
    end
  end

  // Write port: copy writes last cycle's read data, fill writes the constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (len_sat != '0) && bus.mode) begin
            we <= 1'b1;
            wa <= bus.dst;
            wd <= bus.fill;
          end
        end
        S_PRIME: begin
          we <= 1'b1;
          wa <= dst_base;
          wd <= bus.q;
        end
        S_STREAM: begin
          we <= 1'b1;
          wa <= wa_next;
          wd <= bus.q;
        end
        S_FILLING: begin
          if (last_elem) begin
            we <= 1'b0;
          end else begin
            wa <= wa_next;
          end
        end
        default: begin
          we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.re   = re;
  assign bus.ra   = ra;
  assign bus.we   = we;
  assign bus.wa   = wa;
  assign bus.wd   = wd;

endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - self-checking bench for ram_block_mover
module tb_ram_block_mover;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_block_mover_if #(.AW(AW), .DW(DW)) bus ();
  ram_block_mover #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // RAM: synchronous write, combinational read, plus a bench preload port
  logic [7:0] mem [1024];
  logic [7:0] mem_model [1024];
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  assign bus.q = mem[bus.ra];
  always @(posedge clk) begin
    if (bus.we) mem[bus.wa] <= bus.wd;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [9:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];
  int lat, nre, nwe, first_re, first_we, last_we, busy_low, busy_at_done, tail_hi;

  typedef struct {
    bit         mode;
    logic [9:0] src;
    logic [9:0] dst;
    logic [10:0] len;
    logic [7:0] fill;
    bit         preload;
    int         restrike;
    bit         poke;
    int         exp_lat;
    int         exp_nre;
    int         exp_nwe;
    logic [9:0] exp_first;
    logic [9:0] exp_last;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic preload_word(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    mem_model[a] = d;
  endtask

  // Reference: memmove through a temporary buffer, element order from the copy direction
  task automatic model_cmd(input bit mode, input logic [9:0] src, input logic [9:0] dst,
                           input logic [10:0] len, input logic [7:0] fill);
    int n;
    bit desc;
    logic [7:0] tmp [1024];
    n = (len > 11'd1024) ? 1024 : int'(len);
    desc = !mode && (dst > src);
    exp_wa_q.delete();
    exp_wd_q.delete();
    for (int k = 0; k < n; k++) tmp[k] = mode ? fill : mem_model[10'((int'(src) + k) % 1024)];
    for (int i = 0; i < n; i++) begin
      int k;
      k = desc ? n - 1 - i : i;
      exp_wa_q.push_back(10'((int'(dst) + k) % 1024));
      exp_wd_q.push_back(tmp[k]);
    end
    for (int k = 0; k < n; k++) mem_model[10'((int'(dst) + k) % 1024)] = tmp[k];
  endtask

  task automatic run_cmd(input bit mode, input logic [9:0] src, input logic [9:0] dst,
                         input logic [10:0] len, input logic [7:0] fill,
                         input int restrike, input bit poke);
    bit seen;
    wa_q.delete(); wd_q.delete();
    lat = 0; nre = 0; nwe = 0; first_re = 0; first_we = 0; last_we = 0;
    busy_low = 0; busy_at_done = 0; tail_hi = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = mode; bus.src = src; bus.dst = dst; bus.len = len; bus.fill = fill;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mode = 1'($urandom); bus.src = 10'($urandom);
    bus.dst = 10'($urandom); bus.len = 11'($urandom); bus.fill = 8'($urandom);
    seen = 1'b0;
    for (int k = 1; k <= 1200 && !seen; k++) begin
      @(negedge clk);
      if (bus.re) begin nre++; if (nre == 1) first_re = k; end
      if (bus.we) begin
        nwe++; if (nwe == 1) first_we = k; last_we = k;
        wa_q.push_back(bus.wa); wd_q.push_back(bus.wd);
      end
      if (bus.done) begin lat = k; seen = 1'b1; busy_at_done = int'(bus.busy); end
      else if (!bus.busy) busy_low++;
      if (restrike != 0 && k == restrike) begin
        bus.start = 1'b1; bus.mode = 1'b1; bus.src = 10'h300; bus.dst = 10'h011;
        bus.len = 11'd4; bus.fill = 8'hEE;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (poke) begin
      bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 10'h000; bus.len = 11'd5; bus.fill = 8'hFF;
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.done || bus.re || bus.we) tail_hi++;
    end
  endtask

  task automatic mem_check(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== mem_model[a]) bad++;
    check(name, bad, 0);
  endtask

  task automatic common_checks(input string tag);
    int bad;
    bad = 0;
    if (wa_q.size() != exp_wa_q.size()) bad = 1 + wa_q.size();
    else for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== exp_wa_q[i] || wd_q[i] !== exp_wd_q[i]) bad++;
    check({tag, "_trace"}, bad, 0);
    if (nwe > 0) check({tag, "_we_contig"}, last_we - first_we + 1, nwe);
    if (nre > 0) check({tag, "_re_lead"}, first_we - first_re, 1);
    check({tag, "_busy_gap"}, busy_low, 0);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    check({tag, "_idle_tail"}, tail_hi, 0);
    mem_check({tag, "_mem"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill = '0;

    //          mode  src      dst      len      fill   pre   rs pk  lat   nre nwe   first    last
    vecs[0] = '{1'b1, 10'h000, 10'h3F0, 11'd32,  8'hA5, 1'b0, 0, 1'b0, 33,   0, 32,   10'h3F0, 10'h00F};
    vecs[1] = '{1'b0, 10'h100, 10'h0FE, 11'd8,   8'h00, 1'b1, 0, 1'b0, 10,   8, 8,    10'h0FE, 10'h105};
    vecs[2] = '{1'b0, 10'h100, 10'h102, 11'd8,   8'h00, 1'b1, 0, 1'b0, 10,   8, 8,    10'h109, 10'h102};
    vecs[3] = '{1'b0, 10'h010, 10'h020, 11'd0,   8'h00, 1'b0, 0, 1'b0, 1,    0, 0,    10'h000, 10'h000};
    vecs[4] = '{1'b0, 10'h005, 10'h200, 11'd1,   8'h00, 1'b0, 0, 1'b0, 3,    1, 1,    10'h200, 10'h200};
    vecs[5] = '{1'b1, 10'h000, 10'h155, 11'd1100, 8'h3C, 1'b0, 0, 1'b0, 1025, 0, 1024, 10'h155, 10'h154};
    vecs[6] = '{1'b0, 10'h200, 10'h300, 11'd16,  8'h00, 1'b0, 5, 1'b0, 18,  16, 16,   10'h30F, 10'h300};
    vecs[7] = '{1'b0, 10'h040, 10'h040, 11'd4,   8'h00, 1'b0, 0, 1'b1, 6,    4, 4,    10'h040, 10'h043};
    vecs[8] = '{1'b1, 10'h000, 10'h3FF, 11'd1,   8'h77, 1'b0, 0, 1'b1, 2,    0, 1,    10'h3FF, 10'h3FF};
    vecs[9] = '{1'b1, 10'h000, 10'h123, 11'd0,   8'h99, 1'b0, 0, 1'b1, 1,    0, 0,    10'h000, 10'h000};

    rst_n = 1'b0;
    for (int a = 0; a < 1024; a++) preload_word(10'(a), 8'($urandom));

    check("reset_ctrl", 32'({bus.busy, bus.done, bus.re, bus.we}), 0);
    check("reset_addr", 32'({bus.ra, bus.wa, bus.wd}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (vecs[i].preload)
        for (int j = 0; j < 8; j++) preload_word(10'(10'h100 + j), 8'(j + 1));
      model_cmd(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill);
      run_cmd(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill,
              vecs[i].restrike, vecs[i].poke);
      check({tag, "_latency"}, lat, vecs[i].exp_lat);
      check({tag, "_re_cycles"}, nre, vecs[i].exp_nre);
      check({tag, "_we_cycles"}, nwe, vecs[i].exp_nwe);
      if (vecs[i].exp_nwe > 0) begin
        check({tag, "_first_wa"}, 32'((wa_q.size() > 0) ? wa_q[0] : 10'bx), 32'(vecs[i].exp_first));
        check({tag, "_last_wa"}, 32'((wa_q.size() > 0) ? wa_q[$] : 10'bx), 32'(vecs[i].exp_last));
      end
      if (vecs[i].preload) begin
        check({tag, "_word_first"}, 32'(mem[vecs[i].dst]), 1);
        check({tag, "_word_last"}, 32'(mem[10'(vecs[i].dst + 10'd7)]), 8);
      end
      common_checks(tag);
    end

    for (int r = 0; r < 24; r++) begin
      bit m;
      int n;
      logic [9:0] s, d;
      logic [7:0] f;
      string tag;
      tag = $sformatf("r%0d", r);
      m = 1'($urandom_range(0, 1));
      n = int'($urandom_range(0, 48));
      f = 8'($urandom);
      s = 10'($urandom_range(0, 1024 - n));
      d = m ? 10'($urandom) : 10'($urandom_range(0, 1024 - n));
      model_cmd(m, s, d, 11'(n), f);
      run_cmd(m, s, d, 11'(n), f, 0, 1'b0);
      check({tag, "_latency"}, lat, (n == 0) ? 1 : (m ? n + 1 : n + 2));
      check({tag, "_re_cycles"}, nre, m ? 0 : n);
      check({tag, "_we_cycles"}, nwe, n);
      common_checks(tag);
    end

    begin
      int quiet;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 1'b0; bus.src = 10'h280; bus.dst = 10'h200;
      bus.len = 11'd16; bus.fill = 8'h00;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      check("rstmid_streaming", 32'({bus.re, bus.we, bus.busy}), 32'h7);
      rst_n = 1'b0;
      #1;
      check("rstmid_ctrl", 32'({bus.busy, bus.done, bus.re, bus.we}), 0);
      check("rstmid_addr", 32'({bus.ra, bus.wa, bus.wd}), 0);
      for (int i = 0; i < 3; i++) mem_model[10'(10'h200 + i)] = mem_model[10'(10'h280 + i)];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      quiet = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (bus.done || bus.busy || bus.re || bus.we) quiet++;
      end
      check("rstmid_quiet", quiet, 0);
      mem_check("rstmid_mem");
      model_cmd(1'b0, 10'h010, 10'h3A0, 11'd5, 8'h00);
      run_cmd(1'b0, 10'h010, 10'h3A0, 11'd5, 8'h00, 0, 1'b0);
      check("post_rst_latency", lat, 7);
      common_checks("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus-initiator engine that drives the read port (RE/RA/Q) and write port (WE/WA/WD) of the 1024-word x 8-bit synchronous-write, combinational-read RAM.
- Performs block copy (memmove semantics) or block fill of up to 1024 words, then signals completion.
- Sits between the CPU control unit and data RAM. It issues the access sequence that the RAM only responds to.

Parameters:
- AW, 10, address width; RAM depth is 2^AW words.
- DW, 8, data word width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  command strobe; sampled only in IDLE.
- MODE  input  1  0 = copy, 1 = fill.
- SRC  input  AW  copy source base address.
- DST  input  AW  destination base address.
- LEN  input  AW+1  word count, 0..2^AW; values above 2^AW saturate to 2^AW.
- FILL  input  DW  fill value (MODE=1).
- BUSY  output  1  high while a command is in progress.
- DONE  output  1  one-cycle completion pulse.
- RE  output  1  RAM read enable.
- RA  output  AW  RAM read address.
- Q  input  DW  RAM read data, valid combinationally for the current RA.
- WE  output  1  RAM write enable.
- WA  output  AW  RAM write address.
- WD  output  DW  RAM write data.

Behaviour:
- Reset (async, RST_N=0): state IDLE; BUSY, DONE, RE and WE are 0; RA, WA and WD are 0; all latched command fields are cleared. Reset mid-transfer aborts immediately and produces no DONE. Words already written stay written.
- States: IDLE, PRIME, STREAM, DRAIN, FILLING, FINISH.
- IDLE:
  - START=1 latches MODE, SRC, DST, saturated LEN and FILL, and sets BUSY=1 on the same edge.
  - LEN=0 goes to FINISH with no RAM access.
  - Otherwise MODE=1 goes to FILLING. MODE=0 goes to PRIME, or to DRAIN-capable PRIME when LEN=1.
- START while BUSY=1 is ignored. Command inputs are don't-care after the accepting edge.
- Copy direction is fixed at acceptance:
  - Descending if DST > SRC (unsigned), else ascending. DST == SRC is ascending; the engine still performs the full read/write sequence.
  - Ascending: element k uses source SRC+k and destination DST+k.
  - Descending: element k uses source SRC+LEN-1-k and destination DST+LEN-1-k.
  - All addresses are mod 2^AW.
  - Overlap-correct result is guaranteed only when neither range wraps past 2^AW-1. Wrapped ranges still copy element-by-element in the chosen order.
- Copy pipeline (one word per cycle, read one cycle ahead of write):
  - PRIME: RE=1, RA=src(0), WE=0. The Q value is captured into an internal data register at the clock edge.
  - STREAM, cycle j (j=1..LEN-1): RE=1, RA=src(j); WE=1, WA=dst(j-1), WD=data register. The register then captures Q.
  - DRAIN: RE=0; WE=1, WA=dst(LEN-1), WD=data register.
  - A copy of LEN words occupies LEN+1 active cycles. LEN=1 is PRIME then DRAIN.
- Fill: FILLING asserts WE=1, WA=dst(k) in ascending order, WD=FILL for LEN consecutive cycles, with RE=0 throughout.
- FINISH: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
  - START in the FINISH cycle is ignored.
  - Latency from the START edge to DONE high: copy LEN+2 cycles, fill LEN+1 cycles, LEN=0 one cycle.
- Outside active cycles RE=0 and WE=0. RA, WA and WD hold their last values.
- The data register is a DW-bit flop only. The engine never buffers more than one word.

Test Plan:
- Fill: MODE=1, DST=0x3F0, LEN=32, FILL=0xA5 -> WE high 32 consecutive cycles with WA 0x3F0..0x3FF then 0x000..0x00F (wrap). DONE one cycle later. RAM words in that span read 0xA5 and neighbours are untouched.
- Ascending copy: preload 0x100..0x107 = 1..8; SRC=0x100, DST=0x0FE, LEN=8 (overlap) -> 0x0FE..0x105 = 1..8. 9 active cycles, DONE at START+10.
- Descending copy: same preload; SRC=0x100, DST=0x102, LEN=8 -> first WA=0x109, last WA=0x102; 0x102..0x109 = 1..8.
- Edge lengths:
  - LEN=0 -> DONE on the next cycle with no RE/WE pulse.
  - LEN=1 copy 0x005 -> 0x200 -> exactly one RE cycle, then one WE cycle.
  - LEN=1100 -> saturates to 1024 writes.
- Command protection: assert START again mid-copy with different SRC -> ignored and the original transfer completes. START coincident with the FINISH cycle -> ignored.
- Reset mid-copy: drop RST_N during STREAM of a LEN=16 copy -> RE, WE, BUSY, DONE and all addresses go to 0 immediately. After release the engine is idle and no DONE occurs. A new START completes normally.
